inst_fetch: RTL and testbench

- Fetch stage that sits directly upstream of the instruction ROM (InstROM).
- Owns the program counter and drives the ROM address each cycle.
- Captures the combinational ROM output into a fetch/decode pipeline register, holding it under stall.
- Applies absolute branch redirects and detects the halt opcode, so the run terminates cleanly and raises Done.

---
 rtl/inst_fetch.sv | 139 +++++++++++++
 tb/tb_inst_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Fetch stage sitting directly upstream of the instruction ROM.
//
// Owns the program counter, drives the ROM address, and registers the
// combinational ROM output into the fetch/decode pipeline register. It applies
// absolute branch redirects and stops on the halt opcode, raising Done.
//
// Ports:
//   Clk        - system clock, all state updates on the rising edge
//   Reset      - synchronous active-high reset, overrides every other input
//   Start      - begin execution at address 0 (honoured in IDLE or HALTED)
//   Stall      - downstream not ready; hold PC and fetch register
//   BranchEn   - redirect the PC to Target (resolves the instruction in fetch)
//   Target     - absolute branch target
//   InstIn     - ROM data, combinational function of ProgCtr
//   ProgCtr    - current PC, drives the ROM address
//   InstOut    - registered instruction to decode
//   InstPC     - address InstOut was fetched from
//   InstValid  - InstOut holds a live instruction
//   Done       - high while halted
//   CycleCount - saturating count of RUN cycles
module inst_fetch #(
  parameter int unsigned A       = 10,
  parameter int unsigned W       = 10,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic [A-1:0] Target,
  input  logic [W-1:0] InstIn,
  output logic [A-1:0] ProgCtr,
  output logic [W-1:0] InstOut,
  output logic [A-1:0] InstPC,
  output logic         InstValid,
  output logic         Done,
  output logic [15:0]  CycleCount
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic [W-1:0]   inst_q, inst_d;
  logic [A-1:0]   inst_pc_q, inst_pc_d;
  logic           valid_q, valid_d;
  logic [15:0]    cycle_q, cycle_d;
  logic           is_halt;

  assign is_halt = (InstIn[W-1 -: 4] == HALT_OP);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    cycle_d   = cycle_q;

    unique case (state_q)
      StIdle: begin
        pc_d    = '0;
        valid_d = 1'b0;
        if (Start) begin
          state_d = StRun;
          cycle_d = '0;
        end
      end

      StRun: begin
        if (cycle_q != 16'hFFFF) begin
          cycle_d = cycle_q + 16'd1;
        end
        // A branch resolves an older instruction, so it beats both the stall
        // and any halt currently presented by the ROM.
        if (BranchEn) begin
          pc_d    = Target;
          valid_d = 1'b0;
        end else if (!Stall) begin
          inst_d    = InstIn;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          if (is_halt) begin
            state_d = StHalted;
          end else begin
            pc_d = pc_q + A'(1);
          end
        end
      end

      StHalted: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = '0;
          valid_d = 1'b0;
          cycle_d = '0;
        end else if (!Stall) begin
          // Halt instruction is consumed once downstream accepts it.
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      cycle_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      cycle_q   <= cycle_d;
    end
  end

  assign ProgCtr    = pc_q;
  assign InstOut    = inst_q;
  assign InstPC     = inst_pc_q;
  assign InstValid  = valid_q;
  assign Done       = (state_q == StHalted);
  assign CycleCount = cycle_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a ROM model feeds InstIn, directed stimulus pushes the
// expected {InstPC, InstOut} of every fetch into a queue, and a monitor pops
// and compares each newly captured instruction.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, BranchEn;
  logic [9:0]  Target;
  logic [9:0]  InstIn;
  logic [9:0]  ProgCtr;
  logic [9:0]  InstOut;
  logic [9:0]  InstPC;
  logic        InstValid;
  logic        Done;
  logic [15:0] CycleCount;

  int checks   = 0;
  int failures = 0;

  logic [9:0]  rom [1024];
  logic [19:0] exp_q [$];
  logic        prev_stall  = 1'b0;
  logic        prev_branch = 1'b0;

  inst_fetch #(
    .A      (10),
    .W      (10),
    .HALT_OP(4'b1111)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Stall     (Stall),
    .BranchEn  (BranchEn),
    .Target    (Target),
    .InstIn    (InstIn),
    .ProgCtr   (ProgCtr),
    .InstOut   (InstOut),
    .InstPC    (InstPC),
    .InstValid (InstValid),
    .Done      (Done),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  assign InstIn = rom[ProgCtr];

  always @(posedge Clk) begin
    prev_stall  <= Stall;
    prev_branch <= BranchEn;
  end

  // A new instruction was captured iff valid after an edge with no stall/branch.
  always @(negedge Clk) begin
    if (InstValid === 1'b1 && !prev_stall && !prev_branch) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL fetch_unexpected: got pc=%0h inst=%0h, none expected", InstPC, InstOut);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({InstPC, InstOut} !== e) begin
          failures++;
          $display("FAIL fetch: got pc=%0h inst=%0h expected pc=%0h inst=%0h",
                   InstPC, InstOut, e[19:10], e[9:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [9:0] pc, input logic [9:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = {2'b00, i[7:0]};
    rom[4]      = 10'h3FF;
    rom[7]      = 10'h3C0;
    rom[10'h3FF] = 10'h0AA;

    Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0; Target = '0;
    step(); step();
    Reset = 1'b0;
    check("reset_pc",    32'(ProgCtr),    32'h0);
    check("reset_valid", 32'(InstValid),  32'h0);
    check("reset_done",  32'(Done),       32'h0);
    check("reset_cycle", 32'(CycleCount), 32'h0);
    check("reset_inst",  32'(InstOut),    32'h0);

    // Idle ignores stall/branch
    BranchEn = 1'b1; Target = 10'd50; Stall = 1'b1;
    step();
    BranchEn = 1'b0; Stall = 1'b0;
    check("idle_pc", 32'(ProgCtr), 32'h0);

    // Sequential run to halt at 4
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("start_cycle", 32'(CycleCount), 32'h0);
    expect_fetch(10'd0, 10'h000);
    expect_fetch(10'd1, 10'h001);
    expect_fetch(10'd2, 10'h002);
    expect_fetch(10'd3, 10'h003);
    expect_fetch(10'd4, 10'h3FF);
    repeat (5) step();
    check("halt_done",  32'(Done),       32'h1);
    check("halt_pc",    32'(ProgCtr),    32'h4);
    check("halt_cycle", 32'(CycleCount), 32'h5);
    check("halt_valid", 32'(InstValid),  32'h1);
    step();
    check("halted_valid_drop", 32'(InstValid),  32'h0);
    check("halted_pc",         32'(ProgCtr),    32'h4);
    check("halted_cycle",      32'(CycleCount), 32'h5);

    // Restart from halt, then stall while InstPC=2
    rom[4] = 10'h004;
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("restart_done",  32'(Done),       32'h0);
    check("restart_pc",    32'(ProgCtr),    32'h0);
    check("restart_cycle", 32'(CycleCount), 32'h0);
    expect_fetch(10'd0, 10'h000);
    expect_fetch(10'd1, 10'h001);
    expect_fetch(10'd2, 10'h002);
    repeat (3) step();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",     32'(ProgCtr),   32'h3);
      check("stall_instpc", 32'(InstPC),    32'h2);
      check("stall_inst",   32'(InstOut),   32'h002);
      check("stall_valid",  32'(InstValid), 32'h1);
    end
    Stall = 1'b0;
    expect_fetch(10'd3, 10'h003);
    expect_fetch(10'd4, 10'h004);
    expect_fetch(10'd5, 10'h005);
    repeat (3) step();

    // Branch with simultaneous stall while InstPC=5
    BranchEn = 1'b1; Target = 10'd100; Stall = 1'b1;
    step();
    BranchEn = 1'b0; Stall = 1'b0;
    check("br_pc",     32'(ProgCtr),   32'd100);
    check("br_valid",  32'(InstValid), 32'h0);
    check("br_instpc", 32'(InstPC),    32'h5);
    expect_fetch(10'd100, 10'd100);
    step();
    check("br_tgt_valid", 32'(InstValid), 32'h1);

    // Branch beats halt at address 7
    BranchEn = 1'b1; Target = 10'd7;
    step();
    check("to7_pc", 32'(ProgCtr), 32'h7);
    Target = 10'd0;
    step();
    BranchEn = 1'b0;
    check("bbh_done",  32'(Done),      32'h0);
    check("bbh_pc",    32'(ProgCtr),   32'h0);
    check("bbh_valid", 32'(InstValid), 32'h0);
    expect_fetch(10'd0, 10'h000);
    step();
    check("bbh_run_pc", 32'(ProgCtr), 32'h1);

    // Wrap-around from 3FF
    BranchEn = 1'b1; Target = 10'h3FF;
    step();
    BranchEn = 1'b0;
    check("wrap_pre_pc", 32'(ProgCtr), 32'h3FF);
    expect_fetch(10'h3FF, 10'h0AA);
    step();
    check("wrap_pc", 32'(ProgCtr), 32'h0);
    expect_fetch(10'd0, 10'h000);
    step();

    // Reset mid-run at PC 42
    BranchEn = 1'b1; Target = 10'd42;
    step();
    BranchEn = 1'b0;
    check("pc42", 32'(ProgCtr), 32'd42);
    Reset = 1'b1; Start = 1'b1;
    step();
    Reset = 1'b0; Start = 1'b0;
    check("mid_reset_pc",    32'(ProgCtr),    32'h0);
    check("mid_reset_valid", 32'(InstValid),  32'h0);
    check("mid_reset_cycle", 32'(CycleCount), 32'h0);
    check("mid_reset_instpc", 32'(InstPC),    32'h0);
    check("mid_reset_inst",  32'(InstOut),    32'h0);
    step();
    check("mid_reset_idle", 32'(ProgCtr), 32'h0);

    // Run to a halt at 2, Start in RUN ignored, then restart after halt
    rom[2] = 10'h3C5;
    Start = 1'b1;
    step();
    expect_fetch(10'd0, 10'h000);
    expect_fetch(10'd1, 10'h001);
    expect_fetch(10'd2, 10'h3C5);
    step();
    Start = 1'b0;
    check("start_in_run_cycle", 32'(CycleCount), 32'h1);
    repeat (2) step();
    check("h2_done",  32'(Done),       32'h1);
    check("h2_pc",    32'(ProgCtr),    32'h2);
    check("h2_cycle", 32'(CycleCount), 32'h3);
    Stall = 1'b1; BranchEn = 1'b1; Target = 10'd55;
    step();
    Stall = 1'b0; BranchEn = 1'b0;
    check("h2_stall_valid", 32'(InstValid), 32'h1);
    check("h2_br_ignored",  32'(ProgCtr),   32'h2);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("rs_done",  32'(Done),       32'h0);
    check("rs_pc",    32'(ProgCtr),    32'h0);
    check("rs_valid", 32'(InstValid),  32'h0);
    check("rs_cycle", 32'(CycleCount), 32'h0);
    rom[2] = 10'h002;
    expect_fetch(10'd0, 10'h000);
    expect_fetch(10'd1, 10'h001);
    repeat (2) step();
    check("rs_cycle2", 32'(CycleCount), 32'h2);

    // Drain scoreboard with a bound
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending fetches, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
